note_sequencer: RTL and testbench
=================================

# note_sequencer

Plays a fixed melody on the Basys3 speaker by sequencing the tone clock divider. Steps through a song ROM of (note, duration) entries, drives the divider's 17-bit `maxcount` for each note, and gates the tone during rests and inter-note gaps. Sits between the board buttons/switches and `ClockDivider`, replacing the direct switch-to-`maxcount` decoder when song mode is selected.

## Interface
- `BEAT_CYCLES`, 5_000_000: CLK cycles per duration unit (50 ms at 100 MHz)
- `GAP_CYCLES`, 500_000: silent CLK cycles after every entry
- `SONG_LEN`, 16: number of ROM entries, 2..16
- `CLK`  in  1  100 MHz system clock
- `RST`  in  1  synchronous, active-high reset
- `START`  in  1  one-cycle pulse; begins playback from entry 0
- `STOP`  in  1  one-cycle pulse; aborts playback
- `LOOP`  in  1  level; at song end, restart instead of stopping
- `maxcount`  out  17  half-period count to `ClockDivider`
- `TONE_EN`  out  1  1 = speaker driven; 0 = silent (gates SCLK at top level)
- `BUSY`  out  1  1 in any state except IDLE
- `NOTE_IDX`  out  4  index of the current ROM entry

## Operation
- ROM entry (9 bits): `rest` [8], `note` [7:4] (index into note table), `dur` [3:0] (1..15 units; 0 = end marker).
- Note table (package constant, floor(1e8/(2f))): 0 C5=95556, 1 D5=85131, 2 E5=75842, 3 F5=71586, 4 G5=63776, 5 A5=56818, 6 B5=50619, 7 C6=47778; indices 8..15 = 0.
- States: IDLE, LOAD, PLAY, GAP.
  - IDLE: outputs idle. START → LOAD with idx=0.
  - LOAD: reads ROM[idx]. `dur`=0 → song end. Otherwise latch `maxcount` and `rest`, load the timer with dur*BEAT_CYCLES, then → PLAY.
  - PLAY: TONE_EN = !rest. When the timer expires → GAP with the timer loaded to GAP_CYCLES.
  - GAP: TONE_EN=0, `maxcount` held. On expiry: if idx=SONG_LEN-1 → song end; else idx+1 → LOAD.
  - Song end: LOOP=1 → idx=0, LOAD. LOOP=0 → IDLE.
- STOP in any non-IDLE state → IDLE on the next edge. STOP beats START when both are asserted in the same cycle.
- START while BUSY is ignored. STOP in IDLE has no effect.
- LOOP is sampled only at song end.
- Duration product: dur*BEAT_CYCLES is computed at 28-bit width. The timer counts down to 1; expiry happens when the count equals 1.

## Timing
- Reset (RST high at an edge): state=IDLE, maxcount=0, TONE_EN=0, BUSY=0, NOTE_IDX=0, timer=0. RST overrides every other input, including mid-note.
- START sampled at edge N: LOAD during cycle N+1. PLAY with valid `maxcount`/TONE_EN from edge N+2.
- PLAY lasts exactly dur*BEAT_CYCLES cycles. GAP lasts exactly GAP_CYCLES cycles. LOAD lasts 1 cycle.
- Note period: dur*BEAT_CYCLES + GAP_CYCLES + 1 cycles.
- End-marker LOAD: 1 cycle, then IDLE or LOAD(idx 0). It does not enter PLAY.
- STOP at edge N: TONE_EN=0, BUSY=0 and NOTE_IDX=0 from edge N+1. `maxcount` is cleared to 0.
- All outputs are registered; none depend combinationally on inputs.

## Structure
- Package `per1_pkg`:
  - `note_e`
  - `song_entry_t` (packed: rest, note, dur)
  - `state_e`
  - `NOTE_MAXCOUNT[16]` constant
  - `SONG_ROM[16]` constant (default: C5 D5 E5 F5 G5 A5 B5 C6, each dur 4, then end marker)
- Sub-module `beat_timer`: 28-bit load/countdown with `load`, `value`, `expire` pulse. It is used for both PLAY and GAP.
- Top level `main` muxes `maxcount` between `SW_DCDR_SCLK` and `note_sequencer` on a mode switch. SCLK is ANDed with TONE_EN.

## Test plan
Use BEAT_CYCLES=4, GAP_CYCLES=2, default ROM unless noted.
- Reset mid-PLAY: RST for 1 cycle → next cycle all outputs 0, state IDLE. START afterwards restarts from idx 0.
- START, LOOP=0: maxcount=95556 with TONE_EN=1 for 16 cycles, then TONE_EN=0 for 2 cycles, then 85131. After entry 7 (47778) and the end marker: BUSY=0, TONE_EN=0.
- ROM with a rest entry {rest=1, note=4, dur=2}: TONE_EN=0 for 8+2 cycles, maxcount=63776, BUSY=1 throughout.
- LOOP=1, ROM with all 16 entries valid (no marker): after idx 15's GAP, NOTE_IDX returns to 0 and maxcount=ROM[0] with no IDLE cycle.
- STOP and START asserted in the same cycle during GAP: IDLE next cycle. A START alone while BUSY: NOTE_IDX and timer unaffected.
- START immediately after STOP (consecutive cycles): playback begins at idx 0, PLAY two cycles after START.

Source files
------------

// File: rtl/per1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : per1_pkg
// Description : Shared types and constants for the note sequencer: note
//               names, song ROM entry layout, FSM state encoding, the
//               note-to-maxcount table and the default melody.
// Revision    : 1.0 - initial release
// ============================================================================
package per1_pkg;

    // Note names, used as indices into NOTE_MAXCOUNT
    typedef enum logic [3:0] {
        NOTE_C5 = 4'd0,
        NOTE_D5 = 4'd1,
        NOTE_E5 = 4'd2,
        NOTE_F5 = 4'd3,
        NOTE_G5 = 4'd4,
        NOTE_A5 = 4'd5,
        NOTE_B5 = 4'd6,
        NOTE_C6 = 4'd7
    } note_e;

    // One song ROM word: rest flag, note index, duration in beats (0 = end)
    typedef struct packed {
        logic       rest;
        logic [3:0] note;
        logic [3:0] dur;
    } song_entry_t;

    // Sequencer states
    typedef logic [1:0] state_e;
    localparam state_e ST_IDLE = 2'd0;
    localparam state_e ST_LOAD = 2'd1;
    localparam state_e ST_PLAY = 2'd2;
    localparam state_e ST_GAP  = 2'd3;

    // Half-period counts for a 100 MHz clock: floor(1e8 / (2 * f))
    localparam logic [16:0] NOTE_MAXCOUNT [16] = '{
        17'd95556, 17'd85131, 17'd75842, 17'd71586,
        17'd63776, 17'd56818, 17'd50619, 17'd47778,
        17'd0,     17'd0,     17'd0,     17'd0,
        17'd0,     17'd0,     17'd0,     17'd0
    };

    // Builds one ROM word from its fields
    function automatic song_entry_t mk_entry(input logic rest, input note_e note,
                                             input logic [3:0] dur);
        song_entry_t e;
        e.rest = rest;
        e.note = note;
        e.dur  = dur;
        return e;
    endfunction

    localparam song_entry_t END_MARK = '0;

    // Default melody: C major scale upward, four beats per note
    localparam song_entry_t SONG_ROM [16] = '{
        mk_entry(1'b0, NOTE_C5, 4'd4),
        mk_entry(1'b0, NOTE_D5, 4'd4),
        mk_entry(1'b0, NOTE_E5, 4'd4),
        mk_entry(1'b0, NOTE_F5, 4'd4),
        mk_entry(1'b0, NOTE_G5, 4'd4),
        mk_entry(1'b0, NOTE_A5, 4'd4),
        mk_entry(1'b0, NOTE_B5, 4'd4),
        mk_entry(1'b0, NOTE_C6, 4'd4),
        END_MARK, END_MARK, END_MARK, END_MARK,
        END_MARK, END_MARK, END_MARK, END_MARK
    };

endpackage
`default_nettype wire

// File: rtl/beat_timer.sv
`default_nettype none
// ============================================================================
// Module      : beat_timer
// Description : Loadable down-counter. Counts toward zero and flags expiry
//               while the count equals 1, so a load of N gives N cycles.
//               Loading 0 parks the timer.
// Revision    : 1.0 - initial release
// ============================================================================
module beat_timer #(
    parameter int WIDTH = 28
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load wins, otherwise decrement until parked at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : note_sequencer
// Description : Walks the song ROM, driving the tone divider's maxcount for
//               each note and gating the tone during rests and the silent
//               gap that follows every entry. Optional looping at song end.
// Revision    : 1.0 - initial release
// ============================================================================
module note_sequencer
    import per1_pkg::*;
#(
    parameter int          BEAT_CYCLES = 5_000_000,
    parameter int          GAP_CYCLES  = 500_000,
    parameter int          SONG_LEN    = 16,
    parameter song_entry_t ROM [16]    = SONG_ROM
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        STOP,
    input  logic        LOOP,
    output logic [16:0] maxcount,
    output logic        TONE_EN,
    output logic        BUSY,
    output logic [3:0]  NOTE_IDX
);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [16:0] mc_q, mc_d;
    logic        tone_q, tone_d;
    logic        busy_q, busy_d;

    logic        tmr_load;
    logic [27:0] tmr_value;
    logic        tmr_expire;

    song_entry_t entry;
    logic [27:0] dur_cycles;
    logic        last_entry;

    assign entry      = ROM[idx_q];
    assign dur_cycles = 28'(entry.dur) * 28'(BEAT_CYCLES);
    assign last_entry = (idx_q == 4'(SONG_LEN - 1));

    beat_timer #(
        .WIDTH (28)
    ) u_timer (
        .clk_i    (CLK),
        .rst_i    (RST),
        .load_i   (tmr_load),
        .value_i  (tmr_value),
        .expire_o (tmr_expire)
    );

    // Next-state and output decode; STOP overrides whatever the FSM chose
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mc_d      = mc_q;
        tone_d    = tone_q;
        tmr_load  = 1'b0;
        tmr_value = '0;

        case (state_q)
            ST_IDLE: begin
                if (START && !STOP) begin
                    state_d = ST_LOAD;
                    idx_d   = 4'd0;
                end
            end

            ST_LOAD: begin
                if (entry.dur == 4'd0) begin
                    // End marker: restart or go idle
                    idx_d = 4'd0;
                    if (LOOP) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        mc_d    = '0;
                        tone_d  = 1'b0;
                    end
                end else begin
                    state_d   = ST_PLAY;
                    mc_d      = NOTE_MAXCOUNT[entry.note];
                    tone_d    = !entry.rest;
                    tmr_load  = 1'b1;
                    tmr_value = dur_cycles;
                end
            end

            ST_PLAY: begin
                if (tmr_expire) begin
                    state_d   = ST_GAP;
                    tone_d    = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_value = 28'(GAP_CYCLES);
                end
            end

            ST_GAP: begin
                if (tmr_expire) begin
                    if (last_entry) begin
                        idx_d = 4'd0;
                        if (LOOP) begin
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                            mc_d    = '0;
                        end
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_LOAD;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
                mc_d    = '0;
                tone_d  = 1'b0;
            end
        endcase

        if (STOP && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            idx_d     = 4'd0;
            mc_d      = '0;
            tone_d    = 1'b0;
            tmr_load  = 1'b1;
            tmr_value = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            mc_q    <= '0;
            tone_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mc_q    <= mc_d;
            tone_q  <= tone_d;
            busy_q  <= busy_d;
        end
    end

    assign maxcount = mc_q;
    assign TONE_EN  = tone_q;
    assign BUSY     = busy_q;
    assign NOTE_IDX = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_sequencer
// Description : Bench for note_sequencer. Three instances (default melody,
//               short song with a rest, full 16-entry song) share the same
//               stimulus and are compared every cycle with a timeline model
//               that derives the expected outputs from elapsed cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_sequencer;
    import per1_pkg::*;

    localparam int BEAT = 4;
    localparam int GAP  = 2;

    localparam int NOTE_TAB [16] = '{
        95556, 85131, 75842, 71586, 63776, 56818, 50619, 47778,
        0, 0, 0, 0, 0, 0, 0, 0
    };

    // Expected default melody, written out independently of the package
    localparam song_entry_t ROM_A [16] = '{
        9'h004, 9'h014, 9'h024, 9'h034, 9'h044, 9'h054, 9'h064, 9'h074,
        9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000
    };
    // Three-entry song with a rest in the middle; entry 3 lies beyond SONG_LEN
    localparam song_entry_t ROM_R [16] = '{
        9'h001, 9'h142, 9'h071, 9'h013, 9'h000, 9'h000, 9'h000, 9'h000,
        9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000
    };
    // Sixteen valid entries, no end marker
    localparam song_entry_t ROM_L [16] = '{
        9'h001, 9'h012, 9'h023, 9'h031, 9'h042, 9'h153, 9'h061, 9'h072,
        9'h003, 9'h011, 9'h022, 9'h033, 9'h041, 9'h052, 9'h063, 9'h071
    };

    logic CLK, RST, START, STOP, LOOP;
    logic [16:0] mc_a, mc_r, mc_l;
    logic        tone_a, tone_r, tone_l;
    logic        busy_a, busy_r, busy_l;
    logic [3:0]  idx_a, idx_r, idx_l;

    note_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(16)) dut_a (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .LOOP(LOOP),
        .maxcount(mc_a), .TONE_EN(tone_a), .BUSY(busy_a), .NOTE_IDX(idx_a));

    note_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(3), .ROM(ROM_R)) dut_r (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .LOOP(LOOP),
        .maxcount(mc_r), .TONE_EN(tone_r), .BUSY(busy_r), .NOTE_IDX(idx_r));

    note_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(16), .ROM(ROM_L)) dut_l (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .LOOP(LOOP),
        .maxcount(mc_l), .TONE_EN(tone_l), .BUSY(busy_l), .NOTE_IDX(idx_l));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    song_entry_t mrom [3][16];
    int          slen [3];
    bit          m_act [3];
    int          m_k   [3];
    logic [16:0] m_mc0 [3];
    int          e_mc  [3];
    bit          e_tone[3];
    bit          e_busy[3];
    int          e_idx [3];
    string       names [3] = '{"dflt", "rest", "full"};

    // Outputs k cycles after playback began: walk the entries, subtracting
    // each phase's length (1 load, dur*BEAT play, GAP silence)
    function automatic void eval(input int inst, input int k, input logic [16:0] mc0,
                                 output bit ended, output int idx,
                                 output logic [16:0] mc, output bit tone);
        int t, i, dur;
        logic [16:0] prev;
        bit done;
        t = k; i = 0; prev = mc0; done = 0;
        ended = 0; idx = 0; mc = mc0; tone = 0;
        while (!done) begin
            dur = int'(mrom[inst][i].dur);
            t = t - 1;
            if (t <= 0) begin
                idx = i; mc = prev; done = 1;
            end else if (dur == 0) begin
                ended = 1; mc = prev; done = 1;
            end else begin
                t = t - dur * BEAT;
                if (t <= 0) begin
                    idx = i; mc = 17'(NOTE_TAB[mrom[inst][i].note]);
                    tone = !mrom[inst][i].rest; done = 1;
                end else begin
                    prev = 17'(NOTE_TAB[mrom[inst][i].note]);
                    t = t - GAP;
                    if (t <= 0) begin
                        idx = i; mc = prev; done = 1;
                    end else if (i == slen[inst] - 1) begin
                        ended = 1; mc = prev; done = 1;
                    end else begin
                        i++;
                    end
                end
            end
        end
    endfunction

    // Advance each instance's model by one clock edge with the sampled inputs
    task automatic model_step(input bit rst, input bit start, input bit stop, input bit loop);
        bit ended; int idx; logic [16:0] mc; bit tone;
        for (int n = 0; n < 3; n++) begin
            if (rst) begin
                m_act[n] = 0;
            end else if (m_act[n]) begin
                if (stop) begin
                    m_act[n] = 0;
                end else begin
                    m_k[n]++;
                    eval(n, m_k[n], m_mc0[n], ended, idx, mc, tone);
                    if (ended) begin
                        if (loop) begin
                            m_k[n] = 1; m_mc0[n] = mc;
                        end else begin
                            m_act[n] = 0;
                        end
                    end
                end
            end else if (start && !stop) begin
                m_act[n] = 1; m_k[n] = 1; m_mc0[n] = '0;
            end
            if (m_act[n]) begin
                eval(n, m_k[n], m_mc0[n], ended, idx, mc, tone);
                e_mc[n] = int'(mc); e_tone[n] = tone; e_busy[n] = 1; e_idx[n] = idx;
            end else begin
                e_mc[n] = 0; e_tone[n] = 0; e_busy[n] = 0; e_idx[n] = 0;
            end
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int mc, tone, busy, idx;
        for (int n = 0; n < 3; n++) begin
            case (n)
                0:       begin mc = int'(mc_a); tone = int'(tone_a); busy = int'(busy_a); idx = int'(idx_a); end
                1:       begin mc = int'(mc_r); tone = int'(tone_r); busy = int'(busy_r); idx = int'(idx_r); end
                default: begin mc = int'(mc_l); tone = int'(tone_l); busy = int'(busy_l); idx = int'(idx_l); end
            endcase
            check({names[n], ".maxcount"}, mc, e_mc[n]);
            check({names[n], ".TONE_EN"}, tone, int'(e_tone[n]));
            check({names[n], ".BUSY"}, busy, int'(e_busy[n]));
            check({names[n], ".NOTE_IDX"}, idx, e_idx[n]);
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, then compare
    task automatic tick(input bit rst, input bit start, input bit stop, input bit loop);
        RST = rst; START = start; STOP = stop; LOOP = loop;
        @(posedge CLK);
        model_step(rst, start, stop, loop);
        #1;
        check_all();
    endtask

    initial begin
        bit r_loop;
        int r;
        RST = 1'b1; START = 1'b0; STOP = 1'b0; LOOP = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mrom[0][i] = ROM_A[i];
            mrom[1][i] = ROM_R[i];
            mrom[2][i] = ROM_L[i];
        end
        slen = '{16, 3, 16};
        m_act = '{0, 0, 0};
        m_k   = '{0, 0, 0};
        m_mc0 = '{17'd0, 17'd0, 17'd0};

        // Reset state
        repeat (2) tick(1, 0, 0, 0);
        repeat (2) tick(0, 0, 0, 0);

        // Full play-through without looping, past the end marker
        tick(0, 1, 0, 0);
        repeat (175) tick(0, 0, 0, 0);

        // Reset in the middle of a note, then restart
        tick(0, 1, 0, 0);
        repeat (8) tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        repeat (2) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        repeat (20) tick(0, 0, 0, 0);

        // STOP and START together while the default song is in its first gap
        tick(0, 0, 1, 0);
        tick(0, 1, 0, 0);
        repeat (17) tick(0, 0, 0, 0);
        tick(0, 1, 1, 0);
        repeat (2) tick(0, 0, 0, 0);

        // START right after STOP, then a START while busy
        tick(0, 1, 0, 0);
        repeat (5) tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        tick(0, 1, 0, 0);
        repeat (4) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        repeat (10) tick(0, 0, 0, 0);

        // Looping across song end (marker and no-marker cases), then release
        tick(0, 0, 1, 1);
        tick(0, 1, 0, 1);
        repeat (400) tick(0, 0, 0, 1);
        repeat (200) tick(0, 0, 0, 0);

        // Random START/STOP/RST/LOOP traffic
        r_loop = 0;
        for (int c = 0; c < 2500; c++) begin
            r = int'($urandom_range(0, 999));
            if ($urandom_range(0, 199) == 0) r_loop = ~r_loop;
            tick(r < 4, (r >= 4) && (r < 40), (r >= 40) && (r < 52), r_loop);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
